motor_sequencer: RTL and testbench
==================================

MOTOR_SEQUENCER -- requirements
Module: motor_sequencer

Interface
REQ-001 Parameter RAMP_DIV, default 100000, SHALL set the clock cycles per duty ramp step (1 ms at 100 MHz).
REQ-002 Parameter DEAD_CYCLES, default 50000, SHALL set the clock cycles of braked dead time before a direction reversal.
REQ-003 Parameter COOL_CYCLES, default 1000000, SHALL set the minimum clock cycles held in FAULT before a retry.
REQ-004 Parameter RETRY_LIMIT, default 3, SHALL set the number of consecutive overcurrent faults that forces LOCKOUT.
REQ-005 CLK_100MHz  in  1  system clock; all state changes on its rising edge.
REQ-006 RST  in  1  asynchronous, active-high reset.
REQ-007 sw  in  8  operator switches: sw[6:0] = target duty (0-127), sw[7] = requested direction (0 forward, 1 backward).
REQ-008 Over1  in  1  asynchronous flag: motor current above 1 A.
REQ-009 Under750  in  1  asynchronous flag: motor current below 750 mA.
REQ-010 duty  out  7  duty command to the PWM generator.
REQ-011 dir  out  1  direction actually applied to the motor driver.
REQ-012 brake  out  1  high while both motor outputs must be held low.
REQ-013 fault  out  1  high in FAULT or LOCKOUT.
REQ-014 state  out  3  current state encoding for the seven-segment display: IDLE=0, RAMP=1, RUN=2, DECEL=3, DEAD=4, FAULT=5, LOCKOUT=6.

Function
REQ-015 sw, Over1 and Under750 SHALL each pass through a two-flop synchronizer; all rules below use the synchronized values.
REQ-016 A free-running step counter SHALL pulse one cycle every RAMP_DIV cycles; it SHALL restart from 0 on entry to RAMP or DECEL.
REQ-017 IDLE: duty=0, brake=0; when target>0, dir SHALL load sw[7] and the state SHALL go to RAMP.
REQ-018 RAMP: on each step pulse, duty SHALL move 1 toward the target; when duty equals the target, the state SHALL go to RUN.
REQ-019 RUN: a target change SHALL return the state to RAMP; target=0 SHALL ramp duty down to 0 and then enter IDLE.
REQ-020 In RAMP or RUN, if sw[7] differs from dir, the state SHALL go to DECEL.
REQ-021 DECEL: duty SHALL decrement by 1 per step pulse; at duty=0 the state SHALL go to DEAD.
REQ-022 DEAD: brake=1 and duty=0 for exactly DEAD_CYCLES cycles; dir SHALL then load sw[7] and the state SHALL go to RAMP, or to IDLE if target=0.
REQ-023 Duty arithmetic SHALL saturate at 0 and 127; it SHALL never wrap.
REQ-024 Over1 in any state except LOCKOUT SHALL force duty=0 and brake=1 and enter FAULT within 3 cycles of the raw edge; the retry counter SHALL increment, saturating at RETRY_LIMIT.
REQ-025 Over1 SHALL take priority over every simultaneous event: direction change, target change and counter expiry.
REQ-026 FAULT: brake=1; after at least COOL_CYCLES cycles with Under750=1 and Over1=0, the state SHALL go to IDLE; Under750 dropping SHALL restart the cool count.
REQ-027 When the retry counter reaches RETRY_LIMIT, FAULT SHALL exit to LOCKOUT instead of IDLE.
REQ-028 LOCKOUT: duty=0 and brake=1; the block SHALL exit to IDLE only when target=0 for one full step interval, and the retry counter SHALL clear on that exit.
REQ-029 The retry counter SHALL clear after 1000 consecutive step pulses in RUN.
REQ-030 All outputs SHALL be registered; state SHALL always equal the registered state.

Reset
REQ-031 RST high SHALL immediately give state=IDLE, duty=0, dir=0, brake=0, fault=0, and clear all counters and synchronizers.
REQ-032 RST asserted mid-ramp, mid-dead-time or in LOCKOUT SHALL abort the operation with no residual count.
REQ-033 After RST deasserts, the first duty change SHALL occur no earlier than one full RAMP_DIV interval.

Verification (RAMP_DIV=4, DEAD_CYCLES=8, COOL_CYCLES=16, RETRY_LIMIT=3)
REQ-034 From IDLE, sw=0x05 -> duty steps 1..5, one step per 4 cycles; state RAMP then RUN; dir=0.
REQ-035 In RUN with duty=5, set sw[7]=1 -> DECEL to 0, DEAD for 8 cycles with brake=1, dir=1, ramp back to 5.
REQ-036 Over1 pulse during RAMP at duty=3 -> duty=0 and fault=1 within 3 cycles; Under750=1 for 16 cycles -> IDLE, then re-ramp.
REQ-037 Three faults without 1000 RUN steps in between -> LOCKOUT; sw[6:0]=0 for 4 cycles -> IDLE with fault=0.
REQ-038 Over1 and a sw[7] toggle on the same cycle -> FAULT; dir unchanged.
REQ-039 RST pulsed in DEAD -> all outputs at reset values on the next sample.

Source files
------------

// File: rtl/motor_sequencer.sv
// Motor duty/direction sequencer: synchronized operator inputs, duty ramping, braked
// direction reversal, overcurrent fault handling with cool-down, retry count and lockout.
module motor_sequencer #(
  parameter int unsigned RAMP_DIV    = 100000,
  parameter int unsigned DEAD_CYCLES = 50000,
  parameter int unsigned COOL_CYCLES = 1000000,
  parameter int unsigned RETRY_LIMIT = 3
) (
  input  logic       CLK_100MHz,
  input  logic       RST,
  input  logic [7:0] sw,
  input  logic       Over1,
  input  logic       Under750,
  output logic [6:0] duty,
  output logic       dir,
  output logic       brake,
  output logic       fault,
  output logic [2:0] state
);

  localparam int unsigned RetryW = $clog2(RETRY_LIMIT + 1) < 1 ? 1 : $clog2(RETRY_LIMIT + 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(RETRY_LIMIT);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRamp    = 3'd1,
    StRun     = 3'd2,
    StDecel   = 3'd3,
    StDead    = 3'd4,
    StFault   = 3'd5,
    StLockout = 3'd6
  } state_e;

  state_e state_q, state_d;
  logic [7:0] sw_s1, sw_s2;
  logic over_s1, over_s2, under_s1, under_s2;
  logic [6:0] duty_q, duty_d;
  logic dir_q, dir_d, brake_q, brake_d, fault_q, fault_d;
  logic [31:0] step_q, step_d, tmr_q, tmr_d;
  logic [9:0] run_q, run_d;
  logic [RetryW-1:0] retry_q, retry_d;

  logic [6:0] target;
  logic req_dir, step;

  assign target  = sw_s2[6:0];
  assign req_dir = sw_s2[7];
  assign step    = (step_q == RAMP_DIV - 1);

  always_ff @(posedge CLK_100MHz or posedge RST) begin
    if (RST) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      over_s1  <= 1'b0;
      over_s2  <= 1'b0;
      under_s1 <= 1'b0;
      under_s2 <= 1'b0;
      state_q  <= StIdle;
      duty_q   <= '0;
      dir_q    <= 1'b0;
      brake_q  <= 1'b0;
      fault_q  <= 1'b0;
      step_q   <= '0;
      tmr_q    <= '0;
      run_q    <= '0;
      retry_q  <= '0;
    end else begin
      sw_s1    <= sw;
      sw_s2    <= sw_s1;
      over_s1  <= Over1;
      over_s2  <= over_s1;
      under_s1 <= Under750;
      under_s2 <= under_s1;
      state_q  <= state_d;
      duty_q   <= duty_d;
      dir_q    <= dir_d;
      brake_q  <= brake_d;
      fault_q  <= fault_d;
      step_q   <= step_d;
      tmr_q    <= tmr_d;
      run_q    <= run_d;
      retry_q  <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    tmr_d   = '0;
    run_d   = '0;
    retry_d = retry_q;

    // Overcurrent outranks every other event in the same cycle.
    if (over_s2 && state_q != StLockout) begin
      state_d = StFault;
      duty_d  = '0;
      if (state_q != StFault && retry_q < RetryMax) retry_d = retry_q + 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          duty_d = '0;
          if (target != '0) begin
            dir_d   = req_dir;
            state_d = StRamp;
          end
        end
        StRamp: begin
          if (req_dir != dir_q) begin
            state_d = StDecel;
          end else if (duty_q == target) begin
            state_d = (target == '0) ? StIdle : StRun;
          end else if (step) begin
            if (duty_q < target && duty_q != 7'd127) duty_d = duty_q + 1'b1;
            else if (duty_q > target && duty_q != 7'd0) duty_d = duty_q - 1'b1;
          end
        end
        StRun: begin
          run_d = run_q;
          if (step) begin
            if (run_q == 10'd999) begin
              retry_d = '0;
              run_d   = '0;
            end else begin
              run_d = run_q + 1'b1;
            end
          end
          if (req_dir != dir_q) state_d = StDecel;
          else if (target != duty_q) state_d = StRamp;
        end
        StDecel: begin
          if (duty_q == '0) state_d = StDead;
          else if (step) duty_d = duty_q - 1'b1;
        end
        StDead: begin
          duty_d = '0;
          if (tmr_q == DEAD_CYCLES - 1) begin
            dir_d   = req_dir;
            state_d = (target == '0) ? StIdle : StRamp;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        StFault: begin
          duty_d = '0;
          if (under_s2) begin
            if (tmr_q >= COOL_CYCLES - 1) state_d = (retry_q >= RetryMax) ? StLockout : StIdle;
            else tmr_d = tmr_q + 1'b1;
          end
        end
        StLockout: begin
          duty_d = '0;
          if (target == '0) begin
            if (tmr_q == RAMP_DIV - 1) begin
              state_d = StIdle;
              retry_d = '0;
            end else begin
              tmr_d = tmr_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Step counter restarts whenever RAMP or DECEL is entered.
    if ((state_d == StRamp || state_d == StDecel) && state_d != state_q) step_d = '0;
    else if (step) step_d = '0;
    else step_d = step_q + 1'b1;

    brake_d = (state_d == StDead) || (state_d == StFault) || (state_d == StLockout);
    fault_d = (state_d == StFault) || (state_d == StLockout);
  end

  assign duty  = duty_q;
  assign dir   = dir_q;
  assign brake = brake_q;
  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: tb/tb_motor_sequencer.sv
// Bench for motor_sequencer: directed scenarios plus randomized target/direction sequences
// checked against the settled outcome the operating rules predict.
module tb_motor_sequencer;

  localparam int unsigned RampDiv = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       over1, under750;
  logic [6:0] duty;
  logic       dir, brake, fault;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  motor_sequencer #(
    .RAMP_DIV   (4),
    .DEAD_CYCLES(8),
    .COOL_CYCLES(16),
    .RETRY_LIMIT(3)
  ) dut (
    .CLK_100MHz(clk),
    .RST       (rst),
    .sw        (sw),
    .Over1     (over1),
    .Under750  (under750),
    .duty      (duty),
    .dir       (dir),
    .brake     (brake),
    .fault     (fault),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget) begin
      if (state == s) begin
        ok = 1'b1;
        break;
      end
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sw = '0; over1 = 1'b0; under750 = 1'b0;
    tick(); tick();
    vectors++;
    if ({state, duty, dir, brake, fault} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got state=%0d duty=%0d dir=%0d brake=%0d fault=%0d want all 0",
               state, duty, dir, brake, fault);
    end
    rst = 1'b0;
    tick(); tick();
    vectors++;
    if (state !== 3'd0 || duty !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_idle: got state=%0d duty=%0d want 0 0", state, duty);
    end
  endtask

  task automatic test_ramp();
    int t, last_t, k;
    bit saw_ramp;
    logic [6:0] prev;
    sw = 8'h05; prev = duty; t = 0; last_t = 0; k = 0; saw_ramp = 0;
    while (state != 3'd2 && t < 100) begin
      tick(); t++;
      if (state == 3'd1) saw_ramp = 1;
      if (duty != prev) begin
        k++;
        vectors++;
        if (duty !== 7'(k)) begin
          miscompares++;
          $display("FAIL ramp_value: got %0d want %0d", duty, k);
        end
        if (k > 1) begin
          vectors++;
          if (t - last_t != RampDiv) begin
            miscompares++;
            $display("FAIL ramp_interval: got %0d want %0d", t - last_t, RampDiv);
          end
        end
        last_t = t;
        prev = duty;
      end
    end
    vectors++;
    if (state !== 3'd2 || duty !== 7'd5 || dir !== 1'b0 || !saw_ramp) begin
      miscompares++;
      $display("FAIL ramp_end: got state=%0d duty=%0d dir=%0d ramp_seen=%0d want 2 5 0 1",
               state, duty, dir, saw_ramp);
    end
  endtask

  task automatic test_reverse();
    int n, dead_n, brake_bad;
    bit ok;
    logic [6:0] prev;
    sw = 8'h85; prev = duty; n = 0;
    while (state != 3'd4 && n < 100) begin
      tick(); n++;
      if (duty != prev) begin
        vectors++;
        if (duty !== prev - 7'd1) begin
          miscompares++;
          $display("FAIL decel_step: got %0d want %0d", duty, prev - 7'd1);
        end
        prev = duty;
      end
    end
    vectors++;
    if (state !== 3'd4 || duty !== 7'd0) begin
      miscompares++;
      $display("FAIL dead_entry: got state=%0d duty=%0d want 4 0", state, duty);
    end
    dead_n = 0; brake_bad = 0;
    while (state == 3'd4 && dead_n < 50) begin
      if (brake !== 1'b1 || duty !== 7'd0) brake_bad++;
      dead_n++;
      tick();
    end
    vectors++;
    if (dead_n != 8 || brake_bad != 0) begin
      miscompares++;
      $display("FAIL dead_time: got %0d cycles (%0d unbraked) want 8 (0)", dead_n, brake_bad);
    end
    vectors++;
    if (dir !== 1'b1 || state !== 3'd1) begin
      miscompares++;
      $display("FAIL dead_exit: got dir=%0d state=%0d want 1 1", dir, state);
    end
    wait_state(3'd2, 100, n, ok);
    vectors++;
    if (!ok || duty !== 7'd5) begin
      miscompares++;
      $display("FAIL reramp: got state=%0d duty=%0d want 2 5", state, duty);
    end
  endtask

  task automatic test_fault();
    int n;
    bit ok;
    sw = 8'h80;
    wait_state(3'd0, 100, n, ok);
    sw = 8'h05; n = 0;
    while (duty != 7'd3 && n < 100) begin
      tick(); n++;
    end
    over1 = 1'b1; n = 0;
    while (!fault && n < 6) begin
      tick(); n++;
      if (n == 1) over1 = 1'b0;
    end
    over1 = 1'b0;
    vectors++;
    if (fault !== 1'b1 || n > 3 || duty !== 7'd0 || brake !== 1'b1 || state !== 3'd5) begin
      miscompares++;
      $display("FAIL fault_entry: got fault=%0d after %0d cycles duty=%0d brake=%0d state=%0d",
               fault, n, duty, brake, state);
    end
    under750 = 1'b1; n = 0;
    while (state == 3'd5 && n < 100) begin
      tick(); n++;
    end
    vectors++;
    if (state !== 3'd0 || n < 16) begin
      miscompares++;
      $display("FAIL cool_exit: got state=%0d after %0d cycles want 0 after >=16", state, n);
    end
    wait_state(3'd2, 100, n, ok);
    vectors++;
    if (!ok || duty !== 7'd5 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_reramp: got state=%0d duty=%0d fault=%0d want 2 5 0", state, duty, fault);
    end
  endtask

  task automatic test_simultaneous();
    int n;
    bit ok, saw_decel;
    sw = 8'h85; over1 = 1'b1; n = 0; saw_decel = 0;
    while (!fault && n < 6) begin
      tick(); n++;
      if (n == 1) over1 = 1'b0;
      if (state == 3'd3) saw_decel = 1;
    end
    over1 = 1'b0;
    vectors++;
    if (state !== 3'd5 || dir !== 1'b0 || saw_decel) begin
      miscompares++;
      $display("FAIL over_priority: got state=%0d dir=%0d decel_seen=%0d want 5 0 0",
               state, dir, saw_decel);
    end
    repeat (8) tick();
    under750 = 1'b0;
    repeat (3) tick();
    under750 = 1'b1; n = 0;
    while (state == 3'd5 && n < 100) begin
      tick(); n++;
    end
    vectors++;
    if (state !== 3'd0 || n < 16) begin
      miscompares++;
      $display("FAIL cool_restart: got state=%0d after %0d cycles want 0 after >=16", state, n);
    end
    wait_state(3'd2, 100, n, ok);
    vectors++;
    if (!ok || dir !== 1'b1) begin
      miscompares++;
      $display("FAIL post_fault_dir: got state=%0d dir=%0d want 2 1", state, dir);
    end
  endtask

  task automatic test_lockout();
    int n;
    bit ok;
    over1 = 1'b1; tick(); over1 = 1'b0;
    wait_state(3'd6, 100, n, ok);
    vectors++;
    if (!ok || fault !== 1'b1 || brake !== 1'b1 || duty !== 7'd0) begin
      miscompares++;
      $display("FAIL lockout_entry: got state=%0d fault=%0d brake=%0d duty=%0d want 6 1 1 0",
               state, fault, brake, duty);
    end
    repeat (10) tick();
    vectors++;
    if (state !== 3'd6) begin
      miscompares++;
      $display("FAIL lockout_hold: got state=%0d want 6", state);
    end
    sw = 8'h80;
    wait_state(3'd0, 30, n, ok);
    vectors++;
    if (!ok || n < RampDiv || fault !== 1'b0 || brake !== 1'b0) begin
      miscompares++;
      $display("FAIL lockout_exit: got state=%0d after %0d cycles fault=%0d brake=%0d want 0 >=4 0 0",
               state, n, fault, brake);
    end
    sw = 8'h85;
    wait_state(3'd2, 100, n, ok);
    over1 = 1'b1; tick(); over1 = 1'b0;
    wait_state(3'd5, 10, n, ok);
    while (state == 3'd5 && n < 100) begin
      tick(); n++;
    end
    vectors++;
    if (state !== 3'd0) begin
      miscompares++;
      $display("FAIL retry_cleared: got state=%0d want 0", state);
    end
  endtask

  task automatic test_random();
    int n, maxd, d, tgt, dr;
    bit ok;
    logic [6:0] prev;
    logic [2:0] exp_state;
    maxd = 0;
    for (int it = 0; it < 11; it++) begin
      tgt = (it == 10) ? 127 : int'($urandom_range(0, 40));
      dr  = int'($urandom_range(0, 1));
      sw  = {dr[0], tgt[6:0]};
      prev = duty;
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 20)) begin
          tick();
          d = (duty > prev) ? int'(duty - prev) : int'(prev - duty);
          if (d > maxd) maxd = d;
          prev = duty;
        end
        tgt = int'($urandom_range(0, 40));
        dr  = int'($urandom_range(0, 1));
        sw  = {dr[0], tgt[6:0]};
      end
      exp_state = (tgt == 0) ? 3'd0 : 3'd2;
      n = 0; ok = 0;
      repeat (3) begin
        tick();
        d = (duty > prev) ? int'(duty - prev) : int'(prev - duty);
        if (d > maxd) maxd = d;
        prev = duty;
      end
      while (n < 1500) begin
        if (state == exp_state && duty == 7'(tgt) && (tgt == 0 || dir == dr[0])) begin
          ok = 1;
          break;
        end
        tick(); n++;
        d = (duty > prev) ? int'(duty - prev) : int'(prev - duty);
        if (d > maxd) maxd = d;
        prev = duty;
      end
      vectors++;
      if (!ok || brake !== 1'b0 || fault !== 1'b0) begin
        miscompares++;
        $display("FAIL random_settle[%0d]: got state=%0d duty=%0d dir=%0d brake=%0d fault=%0d want %0d %0d %0d 0 0",
                 it, state, duty, dir, brake, fault, exp_state, tgt, dr);
      end
    end
    vectors++;
    if (maxd > 1) begin
      miscompares++;
      $display("FAIL duty_slew: got max step %0d want <=1", maxd);
    end
  endtask

  task automatic test_reset_dead();
    int n;
    bit ok;
    sw = 8'h05;
    wait_state(3'd2, 1500, n, ok);
    while ((dir != 1'b0 || duty != 7'd5 || state != 3'd2) && n < 1500) begin
      tick(); n++;
    end
    sw = 8'h85;
    wait_state(3'd4, 200, n, ok);
    tick(); tick();
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (!ok || {state, duty, dir, brake, fault} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_in_dead: got state=%0d duty=%0d dir=%0d brake=%0d fault=%0d (dead reached=%0d) want all 0",
               state, duty, dir, brake, fault, ok);
    end
    tick(); tick();
    rst = 1'b0; n = 0;
    while (duty == 7'd0 && n < 50) begin
      tick(); n++;
    end
    vectors++;
    if (n < RampDiv || duty !== 7'd1 || dir !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_ramp: got first step after %0d cycles duty=%0d dir=%0d want >=4 1 1",
               n, duty, dir);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_reverse();
    test_fault();
    test_simultaneous();
    test_lockout();
    test_random();
    test_reset_dead();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
